multi_button_shaper: RTL and testbench
======================================

MULTI_BUTTON_SHAPER -- requirements
Module: multi_button_shaper

Interface
REQ-001 Parameter N_BTN, default 4, number of independent button channels (1..16).
REQ-002 Parameter DB_CYCLES, default 16, consecutive stable synchronized samples required to accept a press or release (2..255).
REQ-003 Parameter REPEAT_DELAY, default 500, PRESSED-state cycles before the first auto-repeat pulse (used only under BTN_REPEAT_EN).
REQ-004 Parameter REPEAT_PERIOD, default 100, cycles between subsequent auto-repeat pulses (used only under BTN_REPEAT_EN).
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 btn_in  input  N_BTN  raw asynchronous buttons, active-low (0 = pressed).
REQ-008 press_pulse  output  N_BTN  one-cycle, active-high, per-channel accepted-press strobe.
REQ-009 release_pulse  output  N_BTN  one-cycle, active-high, per-channel accepted-release strobe.
REQ-010 btn_level  output  N_BTN  debounced level, 1 while channel in PRESSED or DEB_RELEASE.
REQ-011 any_press  output  1  OR of all press_pulse bits, same cycle.

Function
REQ-012 Each btn_in bit SHALL pass through a two-flop synchronizer before any use; the synchronized value is inverted internally to active-high "pressed".
REQ-013 Each channel SHALL own an FSM with states IDLE, DEB_PRESS, PRESSED, DEB_RELEASE and an 8-bit stability counter; channels SHALL not interact.
REQ-014 IDLE: counter 0; pressed sample -> DEB_PRESS.
REQ-015 DEB_PRESS: counter increments each pressed sample; a released sample -> IDLE with counter cleared; counter reaching DB_CYCLES-1 on a pressed sample -> PRESSED and press_pulse asserted the following cycle only.
REQ-016 PRESSED: released sample -> DEB_RELEASE, counter cleared; otherwise hold.
REQ-017 DEB_RELEASE: counter increments each released sample; a pressed sample -> PRESSED with counter cleared and no pulse; counter reaching DB_CYCLES-1 on a released sample -> IDLE and release_pulse asserted the following cycle only.
REQ-018 Latency: btn_in first sampled low at edge E0 and held low SHALL produce press_pulse high for exactly the cycle following edge E0+DB_CYCLES+2; release is symmetric.
REQ-019 Any glitch shorter than DB_CYCLES synchronized samples SHALL produce no pulse and no btn_level change.
REQ-020 press_pulse and release_pulse for one channel SHALL never be high in the same cycle; pulses on different channels in the same cycle are permitted and reported independently.
REQ-021 All outputs SHALL be registered except any_press.
REQ-022 Unreachable FSM encodings SHALL return to IDLE on the next edge with no pulse.

Reset
REQ-023 While rst=0 at a rising edge: all FSMs -> IDLE, counters 0, synchronizer flops 1 (released), press_pulse, release_pulse, btn_level, repeat counters all 0.
REQ-024 Reset mid-debounce or mid-press SHALL abort without a release_pulse; a button held through reset deassertion SHALL be re-debounced and SHALL produce one press_pulse per REQ-018 timing measured from the first edge with rst=1.

Configuration
REQ-025 Macro BTN_REPEAT_EN defined: in PRESSED, a 16-bit hold counter SHALL emit an extra one-cycle press_pulse after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles, until the channel leaves PRESSED; entering DEB_RELEASE freezes the hold counter, returning to PRESSED resumes it, entering IDLE clears it.
REQ-026 Macro BTN_REPEAT_EN undefined: no hold counter is synthesized, exactly one press_pulse per accepted press, REPEAT_* parameters ignored.

Verification
REQ-027 Reset, N_BTN=4, DB_CYCLES=4; drive btn_in[0]=0 at edge 10 and hold -> press_pulse[0] high only in cycle after edge 16, btn_level[0]=1 thereafter, any_press high same cycle.
REQ-028 btn_in[1] low for 3 cycles then high, repeated 5 times -> no press_pulse[1], btn_level[1] stays 0.
REQ-029 Channel 2 pressed and debounced, then 2-cycle high glitch -> no release_pulse[2]; sustained release -> single release_pulse[2] 6 cycles after release edge.
REQ-030 Channels 0 and 3 pressed on the same edge -> press_pulse=4'b1001 for one cycle, any_press=1 for one cycle.
REQ-031 Channel 0 in PRESSED, assert rst=0 for 2 cycles while held -> no release_pulse, outputs 0 during reset, one press_pulse[0] 6 cycles after rst returns to 1.
REQ-032 BTN_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=8, hold 60 cycles after acceptance -> press_pulse at acceptance, +20, +28, +36, +44, +52; without macro only the acceptance pulse.

Source files
------------

// File: rtl/multi_button_shaper_if.sv
// ---------------------------------------------------------------------------
// multi_button_shaper_if
//   Bundles the button inputs and the shaped outputs of multi_button_shaper.
//   N_BTN         : number of button channels.
//   btn_in        : raw asynchronous buttons, active-low (0 = pressed).
//   press_pulse   : one-cycle accepted-press strobe per channel.
//   release_pulse : one-cycle accepted-release strobe per channel.
//   btn_level     : debounced level per channel (1 = pressed).
//   any_press     : OR of all press_pulse bits, same cycle.
//   master : drives btn_in, observes the shaped outputs (stimulus side).
//   slave  : the shaper itself.
// ---------------------------------------------------------------------------
interface multi_button_shaper_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] btn_level;
  logic             any_press;

  modport master (
    output btn_in,
    input  press_pulse, release_pulse, btn_level, any_press
  );

  modport slave (
    input  btn_in,
    output press_pulse, release_pulse, btn_level, any_press
  );
endinterface

// File: rtl/multi_button_shaper.sv
// ---------------------------------------------------------------------------
// multi_button_shaper
//   Per-channel button synchronizer + debouncer producing one-cycle press and
//   release strobes and a debounced level. Channels are fully independent.
//
//   Optional feature macro: BTN_REPEAT_EN
//     defined   : while a button stays accepted-pressed, extra press pulses
//                 are emitted after REPEAT_DELAY cycles and then every
//                 REPEAT_PERIOD cycles (16-bit hold counter per channel).
//     undefined : no hold counter; exactly one press pulse per acceptance.
//
//   Parameters
//     N_BTN         : channel count (1..16)
//     DB_CYCLES     : debounce length in synchronized samples (2..255)
//     REPEAT_DELAY  : hold cycles before the first repeat pulse
//     REPEAT_PERIOD : cycles between later repeat pulses
//
//   Ports
//     clk  : clock, rising edge
//     rst  : synchronous reset, active-low
//     bus  : multi_button_shaper_if.slave (btn_in in; press_pulse,
//            release_pulse, btn_level registered out; any_press combinational)
// ---------------------------------------------------------------------------

// One button channel: two-flop synchronizer, debounce FSM, registered outputs.
//   btn_n_i   : raw button, active-low
//   press_o   : accepted press (or repeat) strobe
//   release_o : accepted release strobe
//   level_o   : 1 while in PRESSED or DEB_RELEASE
module mbs_channel #(
  parameter int DB_CYCLES     = 16
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o,
  output logic release_o,
  output logic level_o
);
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

  logic       sync1_q, sync2_q;
  state_t     state_q;
  logic [7:0] cnt_q;
  logic       press_q, release_q, level_q;
  logic       pressed;

`ifdef BTN_REPEAT_EN
  localparam logic [15:0] DLY_LAST = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PER_LAST = 16'(REPEAT_PERIOD - 1);
  logic [15:0] hold_q;
  logic        rep_q;   // first repeat already issued: pace by PERIOD
`endif

  // Synchronized sample, flipped to active-high "pressed".
  assign pressed = ~sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
`ifdef BTN_REPEAT_EN
      hold_q    <= 16'd0;
      rep_q     <= 1'b0;
`endif
    end else begin
      sync1_q   <= btn_n_i;
      sync2_q   <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q   <= 8'd0;
          level_q <= 1'b0;
          if (pressed) state_q <= DEB_PRESS;
`ifdef BTN_REPEAT_EN
          hold_q  <= 16'd0;
          rep_q   <= 1'b0;
`endif
        end
        DEB_PRESS: begin
          level_q <= 1'b0;
          if (!pressed) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= 8'd0;
            press_q <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`ifdef BTN_REPEAT_EN
          hold_q  <= 16'd0;
          rep_q   <= 1'b0;
`endif
        end
        PRESSED: begin
          level_q <= 1'b1;
          if (!pressed) begin
            state_q <= DEB_RELEASE;
            cnt_q   <= 8'd0;
          end
`ifdef BTN_REPEAT_EN
          // Hold time only advances on edges that stay in PRESSED.
          else if (hold_q == (rep_q ? PER_LAST : DLY_LAST)) begin
            press_q <= 1'b1;
            hold_q  <= 16'd0;
            rep_q   <= 1'b1;
          end else begin
            hold_q <= hold_q + 16'd1;
          end
`endif
        end
        DEB_RELEASE: begin
          // Hold counter is left untouched here so a bounce resumes it.
          level_q <= 1'b1;
          if (pressed) begin
            state_q <= PRESSED;
            cnt_q   <= 8'd0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
          level_q <= 1'b0;
`ifdef BTN_REPEAT_EN
          hold_q  <= 16'd0;
          rep_q   <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign level_o   = level_q;
endmodule

module multi_button_shaper #(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_button_shaper_if.slave  bus
);
  logic [N_BTN-1:0] press_w, release_w, level_w;

  // Out-of-range settings show up as this named scope in the elaborated
  // hierarchy; the repeat parameters are range-checked even when unused.
  if (N_BTN < 1 || N_BTN > 16 || DB_CYCLES < 2 || DB_CYCLES > 255 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 65535 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > 65535) begin : g_bad_params
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    mbs_channel #(
      .DB_CYCLES     (DB_CYCLES)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_n_i   (bus.btn_in[i]),
      .press_o   (press_w[i]),
      .release_o (release_w[i]),
      .level_o   (level_w[i])
    );
  end

  assign bus.press_pulse   = press_w;
  assign bus.release_pulse = release_w;
  assign bus.btn_level     = level_w;
  assign bus.any_press     = |press_w;
endmodule

// File: tb/tb_multi_button_shaper.sv
module tb_multi_button_shaper;
  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_button_shaper_if #(.N_BTN(N)) bus ();

  multi_button_shaper #(
    .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int err   = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once DB+1 consecutive synchronized samples
  // disagree with it; repeats fire at held = RD, RD+RP, RD+2RP, ... where
  // held counts settled-pressed edges since acceptance.
  logic [N-1:0] dly0, dly1, m_lvl, m_press, m_rel;
  int run [N];
  int held[N];

  task automatic model_edge(input logic r, input logic [N-1:0] b);
    if (!r) begin
      dly0 = '1; dly1 = '1; m_lvl = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < N; i++) begin run[i] = 0; held[i] = 0; end
    end else begin
      m_press = '0; m_rel = '0;
      for (int i = 0; i < N; i++) begin
        logic p;
        p = ~dly1[i];
        if (p != m_lvl[i]) begin
          run[i]++;
          if (run[i] == DB + 1) begin
            m_lvl[i] = p; run[i] = 0; held[i] = 0;
            if (p) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
          end
        end else begin
          if (REP && m_lvl[i] && run[i] == 0) begin
            held[i]++;
            if (held[i] == RD || (held[i] > RD && (held[i] - RD) % RP == 0))
              m_press[i] = 1'b1;
          end
          run[i] = 0;
        end
      end
      dly1 = dly0;
      dly0 = b;
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] b);
    rst = r;
    bus.btn_in = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    chk("model press",   bus.press_pulse,   m_press);
    chk("model release", bus.release_pulse, m_rel);
    chk("model level",   bus.btn_level,     m_lvl);
    chk("model any",     bus.any_press,     |m_press);
    chk("press&release", bus.press_pulse & bus.release_pulse, '0);
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] b;
    int           n;
    logic [N-1:0] ep, er, el;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic [N-1:0] b, input int n,
                     input logic [N-1:0] ep, input logic [N-1:0] er, input logic [N-1:0] el);
    vec_t v;
    v.r = r; v.b = b; v.n = n; v.ep = ep; v.er = er; v.el = el;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] F;
    int offs[$];
    int exp_offs[$];
    logic [N-1:0] cur;
    int rem[N];
    bit found;
    F = '1;

    // Reset, then channel 0 first sampled low at edge 10 -> pulse after edge 16
    add(0, F, 2, 0, 0, 0);
    add(1, F, 7, 0, 0, 0);
    add(1, 4'b1110, 6, 0, 0, 0);
    add(1, 4'b1110, 1, 4'b0001, 0, 4'b0001);
    add(1, 4'b1110, 3, 0, 0, 4'b0001);
    add(1, F, 6, 0, 0, 4'b0001);
    add(1, F, 1, 0, 4'b0001, 0);
    add(1, F, 3, 0, 0, 0);
    // Channels 0 and 3 on the same edge
    add(1, 4'b0110, 6, 0, 0, 0);
    add(1, 4'b0110, 1, 4'b1001, 0, 4'b1001);
    add(1, 4'b0110, 3, 0, 0, 4'b1001);
    add(1, F, 6, 0, 0, 4'b1001);
    add(1, F, 1, 0, 4'b1001, 0);
    add(1, F, 2, 0, 0, 0);
    // Channel 1: five 3-cycle low glitches
    for (int k = 0; k < 5; k++) begin
      add(1, 4'b1101, 3, 0, 0, 0);
      add(1, F, 3, 0, 0, 0);
    end
    add(1, F, 2, 0, 0, 0);
    // Channel 2: accept, 2-cycle release bounce, then sustained release
    add(1, 4'b1011, 6, 0, 0, 0);
    add(1, 4'b1011, 1, 4'b0100, 0, 4'b0100);
    add(1, 4'b1011, 2, 0, 0, 4'b0100);
    add(1, F, 2, 0, 0, 4'b0100);
    add(1, 4'b1011, 6, 0, 0, 4'b0100);
    add(1, F, 6, 0, 0, 4'b0100);
    add(1, F, 1, 0, 4'b0100, 0);
    add(1, F, 2, 0, 0, 0);
    // Channel 0 pressed, reset for 2 cycles while held, re-debounced
    add(1, 4'b1110, 6, 0, 0, 0);
    add(1, 4'b1110, 1, 4'b0001, 0, 4'b0001);
    add(1, 4'b1110, 3, 0, 0, 4'b0001);
    add(0, 4'b1110, 2, 0, 0, 0);
    add(1, 4'b1110, 6, 0, 0, 0);
    add(1, 4'b1110, 1, 4'b0001, 0, 4'b0001);
    add(1, 4'b1110, 2, 0, 0, 4'b0001);
    add(1, F, 6, 0, 0, 4'b0001);
    add(1, F, 1, 0, 4'b0001, 0);
    add(1, F, 2, 0, 0, 0);
    // Channel 3: reset in mid-debounce aborts it
    add(1, 4'b0111, 4, 0, 0, 0);
    add(0, 4'b0111, 1, 0, 0, 0);
    add(1, 4'b0111, 6, 0, 0, 0);
    add(1, 4'b0111, 1, 4'b1000, 0, 4'b1000);
    add(1, F, 6, 0, 0, 4'b1000);
    add(1, F, 1, 0, 4'b1000, 0);
    add(1, F, 2, 0, 0, 0);

    foreach (tbl[j]) begin
      for (int k = 0; k < tbl[j].n; k++) begin
        step(tbl[j].r, tbl[j].b);
        chk($sformatf("vec%0d.%0d press", j, k),   bus.press_pulse,   tbl[j].ep);
        chk($sformatf("vec%0d.%0d release", j, k), bus.release_pulse, tbl[j].er);
        chk($sformatf("vec%0d.%0d level", j, k),   bus.btn_level,     tbl[j].el);
        chk($sformatf("vec%0d.%0d any", j, k),     bus.any_press,     |tbl[j].ep);
      end
    end

    // Long hold on channel 1: acceptance pulse, then repeats if enabled
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1, 4'b1101);
      if (bus.press_pulse[1]) found = 1'b1;
    end
    chk("hold accept seen", found, 1);
    for (int k = 1; k < 60; k++) begin
      step(1, 4'b1101);
      if (bus.press_pulse[1]) offs.push_back(k);
    end
    if (REP) exp_offs = '{20, 28, 36, 44, 52};
    chk("repeat count", offs.size(), exp_offs.size());
    for (int j = 0; j < exp_offs.size() && j < offs.size(); j++)
      chk($sformatf("repeat offset %0d", j), offs[j], exp_offs[j]);
    for (int k = 0; k < 10; k++) step(1, F);

    // Randomized run against the model
    cur = F;
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          cur[i] = ~cur[i];
          rem[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 8);
        end
        rem[i]--;
      end
      step($urandom_range(0, 299) != 0, cur);
    end

    $display("Result: errors=%0d of %0d checks", err, total);
    $finish;
  end
endmodule
